// File: rtl/neuron_mac.sv
// Streaming signed dot-product engine: unsigned activations times signed weights, two-stage pipeline.
// Optional NEURON_MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module neuron_mac #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned WEIGHT_W  = 10,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned MAX_TERMS = 64,
    localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [WEIGHT_W-1:0]     in_weight,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_ovf
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
`ifdef NEURON_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                    state;
    logic                      drain_phase;
    logic [CNT_W-1:0]          cnt;
    logic                      cnt_ovf;
    logic                      accept;

    logic signed [PROD_W-1:0]  data_x;
    logic signed [PROD_W-1:0]  weight_x;
    logic signed [PROD_W-1:0]  prod;

    logic                      s1_valid;
    logic                      s1_first;
    logic signed [PROD_W-1:0]  s1_prod;

    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      acc_ovf;
    logic                      add_ovf;
`ifdef NEURON_MAC_SATURATE_EN
    logic                      acc_sat;
`endif

    assign accept = in_valid && in_ready;

    // Unsigned x signed product always fits in DATA_W+WEIGHT_W signed bits
    always_comb begin
        data_x   = {{WEIGHT_W{1'b0}}, in_data};
        weight_x = {{DATA_W{in_weight[WEIGHT_W-1]}}, in_weight};
        prod     = data_x * weight_x;
    end

    always_comb begin
        prod_ext = ACC_W'(s1_prod);
        acc_sum  = acc + prod_ext;
        add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    end

    // Control FSM, term counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drain_phase <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_count   <= '0;
            out_ovf     <= 1'b0;
            cnt         <= '0;
            cnt_ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (state == IDLE) begin
                            cnt     <= CNT_W'(1);
                            cnt_ovf <= 1'b0;
                        end else if (cnt == CNT_MAX) begin
                            cnt_ovf <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            state       <= DRAIN;
                            in_ready    <= 1'b0;
                            drain_phase <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    // Second drain cycle sees the accumulator with the last product folded in
                    drain_phase <= 1'b1;
                    if (drain_phase) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_sum   <= acc;
                        out_count <= cnt;
                        out_ovf   <= acc_ovf || cnt_ovf;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the product of the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod  <= prod;
                s1_first <= (state == IDLE);
            end
        end
    end

    // Stage 2: load on first beat, otherwise accumulate with overflow tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
`ifdef NEURON_MAC_SATURATE_EN
            acc_sat <= 1'b0;
`endif
        end else if (s1_valid) begin
            if (s1_first) begin
                acc     <= prod_ext;
                acc_ovf <= 1'b0;
`ifdef NEURON_MAC_SATURATE_EN
                acc_sat <= 1'b0;
`endif
            end else begin
`ifdef NEURON_MAC_SATURATE_EN
                if (!acc_sat) begin
                    if (add_ovf) begin
                        acc     <= acc[ACC_W-1] ? ACC_NEG : ACC_POS;
                        acc_sat <= 1'b1;
                        acc_ovf <= 1'b1;
                    end else begin
                        acc <= acc_sum;
                    end
                end
`else
                acc <= acc_sum;
                if (add_ovf) begin
                    acc_ovf <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac; runs a default instance and a MAX_TERMS=4 instance
// in lockstep against an arithmetic reference model (honours NEURON_MAC_SATURATE_EN).
module tb_neuron_mac;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned WEIGHT_W = 10;
    localparam int unsigned ACC_W    = 24;
    localparam int unsigned MAX_A    = 64;
    localparam int unsigned MAX_B    = 4;
    localparam int unsigned CNT_A    = $clog2(MAX_A + 1);
    localparam int unsigned CNT_B    = $clog2(MAX_B + 1);
    localparam longint ACC_MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< (ACC_W - 1));
    localparam longint ACC_SPAN = longint'(1) <<< ACC_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    in_valid = 1'b0;
    logic [DATA_W-1:0]       in_data = '0;
    logic [WEIGHT_W-1:0]     in_weight = '0;
    logic                    in_last = 1'b0;
    logic                    out_ready = 1'b0;

    logic                    in_ready_a, in_ready_b;
    logic                    out_valid_a, out_valid_b;
    logic signed [ACC_W-1:0] out_sum_a, out_sum_b;
    logic [CNT_A-1:0]        out_count_a;
    logic [CNT_B-1:0]        out_count_b;
    logic                    out_ovf_a, out_ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0]   dq[$];
    logic [WEIGHT_W-1:0] wq[$];

    neuron_mac #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
        .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    neuron_mac #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
        .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic on the queued beats, then wrap/clamp at the accumulator range
    task automatic model(input int max_terms, output longint s, output int c, output bit o);
        longint acc = 0;
        longint p, e;
        bit sat = 0;
        o = 0;
        for (int i = 0; i < dq.size(); i++) begin
            p = longint'(dq[i]) * longint'($signed(wq[i]));
            if (i == 0) begin
                acc = p;
            end else if (!sat) begin
                e = acc + p;
                if (e > ACC_MAXV || e < ACC_MINV) begin
                    o = 1;
`ifdef NEURON_MAC_SATURATE_EN
                    acc = (e > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
                    sat = 1;
`else
                    acc = (e > ACC_MAXV) ? e - ACC_SPAN : e + ACC_SPAN;
`endif
                end else begin
                    acc = e;
                end
            end
        end
        s = acc;
        c = (dq.size() > max_terms) ? max_terms : dq.size();
        if (dq.size() > max_terms) o = 1;
    endtask

    // Present one beat after `gap` idle cycles; returns just after the accepting edge
    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [WEIGHT_W-1:0] w,
                              input logic l, input int gap);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_last   = l;
        while (!in_ready_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_dot(input int gap_max, input int hold);
        longint es_a, es_b;
        int ec_a, ec_b, lat;
        bit eo_a, eo_b;
        model(MAX_A, es_a, ec_a, eo_a);
        model(MAX_B, es_b, ec_b, eo_b);
        for (int i = 0; i < dq.size(); i++)
            drive_beat(dq[i], wq[i], (i == dq.size() - 1), $urandom_range(gap_max, 0));
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check("drain_ready", in_ready_a, 0);
        end
        check("latency", lat, 2);
        check("valid_b", out_valid_b, 1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_ready", in_ready_a, 0);
            check("hold_valid", out_valid_a, 1);
            check("hold_sum", out_sum_a, es_a);
        end
        check("sum_a", out_sum_a, es_a);
        check("count_a", out_count_a, ec_a);
        check("ovf_a", out_ovf_a, eo_a);
        check("sum_b", out_sum_b, es_b);
        check("count_b", out_count_b, ec_b);
        check("ovf_b", out_ovf_b, eo_b);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pop_valid", out_valid_a, 0);
        check("pop_ready", in_ready_a, 1);
        dq.delete();
        wq.delete();
    endtask

    task automatic push_n(input int n, input logic [DATA_W-1:0] d, input logic [WEIGHT_W-1:0] w);
        for (int i = 0; i < n; i++) begin
            dq.push_back(d);
            wq.push_back(w);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", in_ready_a, 0);
        check("rst_valid", out_valid_a, 0);
        check("rst_sum", out_sum_a, 0);
        check("rst_count", out_count_a, 0);
        check("rst_ovf", out_ovf_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", in_ready_a, 1);

        // Single extreme beat: 1023 * -512
        push_n(1, 10'd1023, 10'h200);
        run_dot(0, 0);
        // Four beats with idle gaps
        push_n(4, 10'd100, 10'd3);
        run_dot(3, 1);
        // Positive overflow
        push_n(17, 10'd1023, 10'd511);
        run_dot(0, 0);
        // Negative overflow
        push_n(17, 10'd1023, 10'h200);
        run_dot(1, 0);
        // Long backpressure
        push_n(2, 10'd7, 10'h3F9);
        run_dot(0, 10);
        // Five 1x1 beats overflow the MAX_TERMS=4 counter only
        push_n(5, 10'd1, 10'd1);
        run_dot(1, 0);
        // Beyond the default MAX_TERMS
        for (int i = 0; i < 70; i++) begin
            dq.push_back(DATA_W'($urandom_range(7, 0)));
            wq.push_back(WEIGHT_W'($urandom));
        end
        run_dot(0, 0);

        // Reset mid-dot-product discards the partial sum
        push_n(1, 10'd300, 10'd300);
        run_dot(0, 0);
        for (int i = 0; i < 3; i++) drive_beat(10'd9, 10'd9, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", out_sum_a, 0);
        check("mid_rst_count", out_count_a, 0);
        check("mid_rst_ready", in_ready_a, 0);
        check("mid_rst_valid", out_valid_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", in_ready_a, 1);
        push_n(2, 10'd5, 10'h3FE);
        run_dot(0, 0);

        // Random dot products
        for (int k = 0; k < 25; k++) begin
            int n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) begin
                dq.push_back(DATA_W'($urandom));
                wq.push_back(WEIGHT_W'($urandom));
            end
            run_dot(2, $urandom_range(3, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL provide parameter DATA_W, default 10, unsigned activation width.
REQ-002 SHALL provide parameter WEIGHT_W, default 10, two's-complement signed weight width.
REQ-003 SHALL provide parameter ACC_W, default 24, signed accumulator/result width; legal only when ACC_W >= DATA_W+WEIGHT_W.
REQ-004 SHALL provide parameter MAX_TERMS, default 64, maximum beats per dot product; CNT_W = clog2(MAX_TERMS+1).
REQ-005 SHALL have port clk  in  1  the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have port in_valid  in  1  an input beat is offered.
REQ-008 SHALL have port in_ready  out  1  the block accepts a beat this cycle.
REQ-009 SHALL have port in_data  in  DATA_W  unsigned activation.
REQ-010 SHALL have port in_weight  in  WEIGHT_W  signed weight.
REQ-011 SHALL have port in_last  in  1  final beat of the current dot product.
REQ-012 SHALL have port out_valid  out  1  result is presented.
REQ-013 SHALL have port out_ready  in  1  downstream consumes the result.
REQ-014 SHALL have port out_sum  out  ACC_W  signed dot-product result.
REQ-015 SHALL have port out_count  out  CNT_W  number of beats summed.
REQ-016 SHALL have port out_ovf  out  1  accumulation overflowed or term count exceeded.

Function
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-018 Product SHALL be the signed product of zero-extended in_data and sign-extended in_weight, DATA_W+WEIGHT_W bits, registered in stage 1.
REQ-019 Stage 2 SHALL add the sign-extended product into the ACC_W accumulator; the first beat of a dot product loads rather than adds.
REQ-020 FSM states SHALL be IDLE (no partial sum), ACCUM (partial sum open), DRAIN (last beat in pipeline) and HOLD (result presented).
REQ-021 Transitions SHALL be: IDLE->ACCUM on an accepted beat with in_last=0; IDLE or ACCUM->DRAIN on an accepted beat with in_last=1; DRAIN->HOLD after two cycles; HOLD->IDLE when out_ready=1.
REQ-022 out_valid SHALL rise exactly 2 cycles after the edge accepting the in_last beat and stay 1 with out_sum/out_count/out_ovf stable until out_ready=1.
REQ-023 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DRAIN and HOLD; there is no result skid buffer.
REQ-024 out_valid and out_ready both 1 SHALL clear out_valid next cycle and set in_ready next cycle.
REQ-025 out_count SHALL saturate at MAX_TERMS; a beat accepted when the count already equals MAX_TERMS SHALL set out_ovf and still be summed.
REQ-026 Signed overflow of the ACC_W accumulator SHALL set out_ovf; out_ovf is sticky for one dot product and clears on the next load.
REQ-027 in_valid=0 mid-dot-product SHALL hold the partial sum indefinitely with no timeout.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, in_ready=0 while asserted, out_valid=0, out_sum=0, out_count=0, out_ovf=0, and clear pipeline and accumulator.
REQ-029 Reset mid-dot-product SHALL discard the partial sum; the first beat after release starts a new dot product.
REQ-030 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Configuration
REQ-031 Macro NEURON_MAC_SATURATE_EN defined: on overflow the accumulator SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and hold there for the rest of the dot product, with out_ovf=1.
REQ-032 Macro NEURON_MAC_SATURATE_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W; out_ovf still reports overflow.

Verification (defaults)
REQ-033 One beat in_data=1023, in_weight=10'h200, in_last=1 -> out_valid 2 cycles later, out_sum=-523776, out_count=1, out_ovf=0.
REQ-034 Four beats in_data=100, in_weight=3, last on 4th, with in_valid gaps -> out_sum=1200, out_count=4.
REQ-035 Seventeen beats in_data=1023, in_weight=511 -> with the macro out_sum=8388607 and out_ovf=1; without it out_sum=-7890415 and out_ovf=1.
REQ-036 out_ready held 0 for 10 cycles after out_valid -> out_sum stable, in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0 and in_ready=1.
REQ-037 rst_n pulsed low after 3 of 5 beats -> outputs zero immediately; then 2 beats of 5x(-2) -> out_sum=-20, out_count=2.
REQ-038 MAX_TERMS=4, five beats of 1x1 -> out_sum=5, out_count=4, out_ovf=1.
